// File: rtl/writeback_regfile.sv
// writeback_regfile
//
// Write-back stage of a Y86-64 style pipeline: the W pipeline register, the
// fifteen-entry general purpose register file and the architectural status.
//
// Optional feature: define WB_RETIRE_CNT_EN to build the retired-instruction
// counter. Without it, 'retired' is tied to zero and no counter flops exist.
//
// Ports
//   clk                  rising-edge clock for all state
//   rst_n                synchronous, active-low reset
//   M_stat, M_icode      memory-stage status and icode
//   M_valE, m_valM       ALU result and memory read data
//   M_dstE, M_dstM       destination registers (15 = none)
//   W_stall, W_bubble    pipeline-control commands for the W register
//   W_stat ... W_valM    W register contents (decode forwards from these)
//   d_srcA, d_srcB       decode read addresses
//   rvalA, rvalB         combinational register-file read data
//   Stat                 architectural processor status
//   halted               sticky flag set by a halting or exceptional retirement
//   retired              count of retired AOK/HLT instructions (optional)

module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] rvalA,
    output logic [63:0] rvalB,
    output logic [2:0]  Stat,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [2:0] STAT_BUB  = 3'd0;
    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam int         NUM_REGS  = 15;
    localparam int         REG_RSP   = 4;

    logic [63:0] regs [0:NUM_REGS-1];
    logic [2:0]  halt_stat;
    logic        reg_write_en;
    logic        halting;

    // Stall wins over bubble, so a stalled instruction is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            W_stat  <= STAT_BUB;
            W_icode <= ICODE_NOP;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
        end else if (W_stall) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
        end else if (W_bubble) begin
            W_stat  <= STAT_BUB;
            W_icode <= ICODE_NOP;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
        end else begin
            W_stat  <= M_stat;
            W_icode <= M_icode;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
        end
    end

    // Only a normally completing instruction changes architectural state.
    assign reg_write_en = !halted && (W_stat == STAT_AOK);
    assign halting      = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) ||
                          (W_stat == STAT_INS);

    // The M-port write comes second so it wins when both ports target the
    // same register (e.g. popq %rsp).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == REG_RSP) ? RSP_INIT : 64'd0;
            end
        end else if (reg_write_en) begin
            if (W_dstE != REG_NONE) begin
                regs[W_dstE] <= W_valE;
            end
            if (W_dstM != REG_NONE) begin
                regs[W_dstM] <= W_valM;
            end
        end
    end

    // Register 15 is "no register" and always reads as zero.
    assign rvalA = (d_srcA == REG_NONE) ? 64'd0 : regs[d_srcA];
    assign rvalB = (d_srcB == REG_NONE) ? 64'd0 : regs[d_srcB];

    // The status code of the first halting retirement is frozen so Stat
    // keeps reporting it while the W register keeps moving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted    <= 1'b0;
            halt_stat <= STAT_AOK;
        end else if (!halted && halting) begin
            halted    <= 1'b1;
            halt_stat <= W_stat;
        end
    end

    // Bubbles report as AOK so the status seen outside never shows a hole.
    always_comb begin
        Stat = W_stat;
        if (halted) begin
            Stat = halt_stat;
        end else if ((W_stat == STAT_BUB) || (W_stat == STAT_AOK)) begin
            Stat = STAT_AOK;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;

    // HLT counts as retired: it completes, it just stops the machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_count <= 32'd0;
        end else if (!halted && ((W_stat == STAT_AOK) || (W_stat == STAT_HLT))) begin
            retire_count <= retire_count + 32'd1;
        end
    end

    assign retired = retire_count;
`else
    assign retired = 32'd0;
`endif

endmodule
